// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges the core's instruction-fetch and data ports onto a
// single memory request bus, one outstanding transaction at a time.
// Optional feature macro: CORE_BUS_ARB_RR_EN (round-robin arbitration).
// When it is undefined, the data port always wins a tie.
module core_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int IDATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    // instruction port
    input  logic               ireq_valid,
    input  logic [ADDR_W-1:0]  ireq_addr,
    output logic               iresp_data_ok,
    output logic [IDATA_W-1:0] iresp_data,
    // data port
    input  logic               dreq_valid,
    input  logic [ADDR_W-1:0]  dreq_addr,
    input  logic [2:0]         dreq_size,
    input  logic [7:0]         dreq_strobe,
    input  logic [DATA_W-1:0]  dreq_data,
    output logic               dresp_data_ok,
    output logic [DATA_W-1:0]  dresp_data,
    // memory bus
    output logic               creq_valid,
    input  logic               creq_ready,
    output logic [ADDR_W-1:0]  creq_addr,
    output logic [2:0]         creq_size,
    output logic [7:0]         creq_strobe,
    output logic [DATA_W-1:0]  creq_data,
    input  logic               cresp_valid,
    input  logic [DATA_W-1:0]  cresp_data
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state;
    logic   owner_d;    // 1: data port owns the transaction, 0: fetch port
    logic   grant_d;
    logic   live_match;

`ifdef CORE_BUS_ARB_RR_EN
    logic   rr_ptr;     // 1: data port wins a tie, 0: fetch port wins

    // Tie goes to the port named by the round-robin pointer
    always_comb begin
        grant_d = dreq_valid && (!ireq_valid || rr_ptr);
    end
`else
    // Data port has fixed priority over the fetch port
    always_comb begin
        grant_d = dreq_valid;
    end
`endif

    // Owner's live request must still equal the captured one to deliver data
    always_comb begin
        live_match = 1'b0;
        if (owner_d)
            live_match = dreq_valid && (dreq_addr == creq_addr) &&
                         (dreq_size == creq_size) && (dreq_strobe == creq_strobe);
        else
            live_match = ireq_valid && (ireq_addr == creq_addr);
    end

    // Transaction FSM; creq fields double as the latched request
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner_d       <= 1'b0;
            creq_valid    <= 1'b0;
            creq_addr     <= '0;
            creq_size     <= '0;
            creq_strobe   <= '0;
            creq_data     <= '0;
            iresp_data_ok <= 1'b0;
            iresp_data    <= '0;
            dresp_data_ok <= 1'b0;
            dresp_data    <= '0;
`ifdef CORE_BUS_ARB_RR_EN
            rr_ptr        <= 1'b0;
`endif
        end else begin
            iresp_data_ok <= 1'b0;
            dresp_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (dreq_valid || ireq_valid) begin
                        owner_d    <= grant_d;
                        creq_valid <= 1'b1;
                        state      <= REQ;
                        if (grant_d) begin
                            creq_addr   <= dreq_addr;
                            creq_size   <= dreq_size;
                            creq_strobe <= dreq_strobe;
                            creq_data   <= dreq_data;
                        end else begin
                            creq_addr   <= ireq_addr;
                            creq_size   <= 3'd2;
                            creq_strobe <= '0;
                            creq_data   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (creq_ready) begin
                        creq_valid <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cresp_valid) begin
                        state <= DONE;
                        // stale responses are dropped without a completion pulse
                        if (live_match) begin
                            if (owner_d) begin
                                dresp_data_ok <= 1'b1;
                                dresp_data    <= cresp_data;
                            end else begin
                                iresp_data_ok <= 1'b1;
                                iresp_data    <= creq_addr[2] ? cresp_data[2*IDATA_W-1:IDATA_W]
                                                              : cresp_data[IDATA_W-1:0];
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef CORE_BUS_ARB_RR_EN
                    if (rr_ptr == owner_d)
                        rr_ptr <= ~rr_ptr;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed-vector bench for core_bus_arbiter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_core_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid;
    logic        creq_ready;
    logic [63:0] creq_addr;
    logic [2:0]  creq_size;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_valid;
    logic [63:0] cresp_data;

    int n_checks = 0;
    int n_errors = 0;
    int ok_cnt   = 0;

    core_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .IDATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .creq_valid    (creq_valid),
        .creq_ready    (creq_ready),
        .creq_addr     (creq_addr),
        .creq_size     (creq_size),
        .creq_strobe   (creq_strobe),
        .creq_data     (creq_data),
        .cresp_valid   (cresp_valid),
        .cresp_data    (cresp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // completion pulses seen by either core port
    always @(negedge clk) begin
        if (iresp_data_ok || dresp_data_ok)
            ok_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Entered in the REQ cycle: checks the request, stalls, accepts, responds.
    // Returns in the DONE cycle.
    task automatic serve(input string tag, input logic [63:0] exp_addr,
                         input logic [63:0] exp_data, input int stall,
                         input logic [63:0] rdata);
        check({tag, "_valid"}, {63'd0, creq_valid}, 64'd1);
        check({tag, "_addr"}, creq_addr, exp_addr);
        check({tag, "_data"}, creq_data, exp_data);
        creq_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            cyc();
            check($sformatf("%s_stall%0d_valid", tag, i), {63'd0, creq_valid}, 64'd1);
            check($sformatf("%s_stall%0d_addr", tag, i), creq_addr, exp_addr);
            check($sformatf("%s_stall%0d_data", tag, i), creq_data, exp_data);
        end
        creq_ready = 1'b1;
        cyc();
        creq_ready = 1'b0;
        check({tag, "_drop_valid"}, {63'd0, creq_valid}, 64'd0);
        cresp_valid = 1'b1;
        cresp_data  = rdata;
        cyc();
        cresp_valid = 1'b0;
        cresp_data  = '0;
    endtask

    initial begin
        int c0;
        reset       = 1'b1;
        ireq_valid  = 1'b0;
        ireq_addr   = '0;
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = '0;
        dreq_strobe = '0;
        dreq_data   = '0;
        creq_ready  = 1'b0;
        cresp_valid = 1'b0;
        cresp_data  = '0;
        repeat (2) cyc();

        check("rst_creq_valid", {63'd0, creq_valid}, 64'd0);
        check("rst_iok", {63'd0, iresp_data_ok}, 64'd0);
        check("rst_dok", {63'd0, dresp_data_ok}, 64'd0);
        check("rst_addr", creq_addr, 64'd0);
        check("rst_strobe", {56'd0, creq_strobe}, 64'd0);
        reset = 1'b0;

        // fetch only: upper word returned for addr bit 2 set
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0004;
        cyc();
        check("f_size", {61'd0, creq_size}, 64'd2);
        check("f_strobe", {56'd0, creq_strobe}, 64'd0);
        check("f_iok_c1", {63'd0, iresp_data_ok}, 64'd0);
        serve("f", 64'h8000_0004, 64'd0, 0, 64'h1111_2222_3333_4444);
        check("f_iok_c3", {63'd0, iresp_data_ok}, 64'd1);
        check("f_idata", {32'd0, iresp_data}, 64'h1111_2222);
        check("f_dok_c3", {63'd0, dresp_data_ok}, 64'd0);
        ireq_valid = 1'b0;
        cyc();
        check("f_iok_c4", {63'd0, iresp_data_ok}, 64'd0);
        check("f_idle_valid", {63'd0, creq_valid}, 64'd0);

        // simultaneous store and fetch: store goes first
        ireq_valid  = 1'b1;
        ireq_addr   = 64'h8000_0000;
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h8010_0008;
        dreq_size   = 3'd3;
        dreq_strobe = 8'hFF;
        dreq_data   = 64'hDEAD_BEEF;
        cyc();
        check("s_strobe", {56'd0, creq_strobe}, 64'hFF);
        serve("s_st", 64'h8010_0008, 64'hDEAD_BEEF, 0, 64'h55);
        check("s_dok", {63'd0, dresp_data_ok}, 64'd1);
        check("s_ddata", dresp_data, 64'h55);
        check("s_iok_st", {63'd0, iresp_data_ok}, 64'd0);
        dreq_valid = 1'b0;
        cyc();
        check("s_idle_valid", {63'd0, creq_valid}, 64'd0);
        check("s_dok_idle", {63'd0, dresp_data_ok}, 64'd0);
        cyc();
        check("s_fe_size", {61'd0, creq_size}, 64'd2);
        serve("s_fe", 64'h8000_0000, 64'd0, 0, 64'hAAAA_BBBB_CCCC_DDDD);
        check("s_fe_iok", {63'd0, iresp_data_ok}, 64'd1);
        check("s_fe_idata", {32'd0, iresp_data}, 64'hCCCC_DDDD);
        ireq_valid = 1'b0;
        cyc();

        // backpressure: five stalled cycles, exactly one completion
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h8020_0000;
        dreq_size   = 3'd2;
        dreq_strobe = 8'h0F;
        dreq_data   = 64'h0123_4567_89AB_CDEF;
        cyc();
        c0 = ok_cnt;
        serve("bp", 64'h8020_0000, 64'h0123_4567_89AB_CDEF, 5, 64'h77);
        check("bp_dok", {63'd0, dresp_data_ok}, 64'd1);
        dreq_valid = 1'b0;
        repeat (3) cyc();
        check("bp_ok_count", 64'(ok_cnt - c0), 64'd1);

        // stale: fetch redirected while waiting for the response
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0010;
        cyc();
        check("st_addr_old", creq_addr, 64'h8000_0010);
        creq_ready = 1'b1;
        cyc();
        creq_ready  = 1'b0;
        ireq_addr   = 64'h8000_0100;
        cresp_valid = 1'b1;
        cresp_data  = 64'h1234_5678_9ABC_DEF0;
        cyc();
        cresp_valid = 1'b0;
        check("st_iok_stale", {63'd0, iresp_data_ok}, 64'd0);
        cyc();
        check("st_idle_valid", {63'd0, creq_valid}, 64'd0);
        check("st_iok_idle", {63'd0, iresp_data_ok}, 64'd0);
        cyc();
        serve("st_new", 64'h8000_0100, 64'd0, 0, 64'h9999_9999_7777_7777);
        check("st_new_iok", {63'd0, iresp_data_ok}, 64'd1);
        check("st_new_idata", {32'd0, iresp_data}, 64'h7777_7777);
        ireq_valid = 1'b0;
        cyc();

        // reset in WAIT, then a late response while the fetch is still held
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0020;
        cyc();
        creq_ready = 1'b1;
        cyc();
        creq_ready = 1'b0;
        reset      = 1'b1;
        cyc();
        reset       = 1'b0;
        check("rw_creq_valid", {63'd0, creq_valid}, 64'd0);
        check("rw_iok", {63'd0, iresp_data_ok}, 64'd0);
        cresp_valid = 1'b1;
        cresp_data  = 64'hFFFF_0000_FFFF_0000;
        cyc();
        cresp_valid = 1'b0;
        check("rw_late_iok", {63'd0, iresp_data_ok}, 64'd0);
        check("rw_regrant_valid", {63'd0, creq_valid}, 64'd1);
        serve("rw_re", 64'h8000_0020, 64'd0, 0, 64'h0000_0001_0000_0002);
        check("rw_re_iok", {63'd0, iresp_data_ok}, 64'd1);
        check("rw_re_idata", {32'd0, iresp_data}, 64'h2);
        ireq_valid = 1'b0;
        cyc();

`ifdef CORE_BUS_ARB_RR_EN
        // round robin: one fetch first moves the pointer to the data port,
        // then both held ports alternate D, I, D, I
        reset = 1'b1;
        cyc();
        reset      = 1'b0;
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0040;
        cyc();
        serve("rr_pre", 64'h8000_0040, 64'd0, 0, 64'h0);
        check("rr_pre_iok", {63'd0, iresp_data_ok}, 64'd1);
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h8030_0000;
        dreq_size   = 3'd3;
        dreq_strobe = 8'h00;
        dreq_data   = '0;
        for (int t = 0; t < 4; t++) begin
            cyc();
            cyc();
            if (t % 2 == 0) begin
                serve($sformatf("rr%0d_d", t), 64'h8030_0000, 64'd0, 0, 64'(t));
                check($sformatf("rr%0d_dok", t), {63'd0, dresp_data_ok}, 64'd1);
                check($sformatf("rr%0d_iok", t), {63'd0, iresp_data_ok}, 64'd0);
            end else begin
                serve($sformatf("rr%0d_i", t), 64'h8000_0040, 64'd0, 0, 64'(t));
                check($sformatf("rr%0d_iok", t), {63'd0, iresp_data_ok}, 64'd1);
                check($sformatf("rr%0d_dok", t), {63'd0, dresp_data_ok}, 64'd0);
            end
        end
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        cyc();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Sits directly downstream of the core top level. Consumes the core's instruction-bus request (ireq/iresp) and data-bus request (dreq/dresp), and merges them onto one shared memory bus (cbus) toward the cache/memory subsystem.
- Supports one outstanding transaction at a time.
- Each core port sees a one-cycle data_ok pulse when its access completes.
- Instruction fetches return a 32-bit word selected from the 64-bit bus beat.

Parameters:
- ADDR_W, 64, address width of all buses.
- DATA_W, 64, cbus and dbus data width; must be 64.
- IDATA_W, 32, width of the instruction returned on iresp.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ireq_valid  in  1  fetch request; core holds it high.
- ireq_addr  in  ADDR_W  fetch address (pc).
- iresp_data_ok  out  1  one-cycle fetch completion pulse.
- iresp_data  out  IDATA_W  fetched instruction, valid while iresp_data_ok=1.
- dreq_valid  in  1  load/store request.
- dreq_addr  in  ADDR_W  data address.
- dreq_size  in  3  log2 access bytes.
- dreq_strobe  in  8  byte write enables; 0 means load.
- dreq_data  in  DATA_W  store data.
- dresp_data_ok  out  1  one-cycle data completion pulse.
- dresp_data  out  DATA_W  load data, valid while dresp_data_ok=1.
- creq_valid  out  1  memory request valid.
- creq_ready  in  1  memory accepts request this cycle.
- creq_addr  out  ADDR_W  latched address.
- creq_size  out  3  latched size; fetch uses 3'd2.
- creq_strobe  out  8  latched strobe; fetch uses 0.
- creq_data  out  DATA_W  latched store data.
- cresp_valid  in  1  memory response valid, one cycle.
- cresp_data  in  DATA_W  response data.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. State and all outputs are registered.
- Reset: state goes to IDLE. creq_valid=0, iresp_data_ok=0, dresp_data_ok=0, all data, address and strobe outputs=0, owner=I, rr pointer=I.
- IDLE:
  - If any request is valid, grant, latch addr/size/strobe/data and owner, and go to REQ. creq_valid is high from the next cycle.
  - Grant policy: dreq wins over ireq when both are valid.
  - If nothing is valid, stay in IDLE.
- REQ: creq_valid=1 and creq fields stable. When creq_ready=1, go to WAIT and drop creq_valid the next cycle.
- WAIT: on cresp_valid=1, capture the response and go to DONE.
- DONE: lasts one cycle, then always returns to IDLE. No grant is issued in DONE, so a core request that is still held is not re-issued before the core updates it.
  - Owner D: dresp_data_ok=1, dresp_data=cresp_data.
  - Owner I: iresp_data_ok=1, iresp_data = latched_addr[2] ? cresp_data[63:32] : cresp_data[31:0].
- Stale check (performed at DONE entry):
  - The captured request is compared against the port's live inputs (valid, addr, and for D also size and strobe).
  - On a mismatch (core flushed or redirected), no data_ok is pulsed and the response is discarded.
  - State still passes through DONE to IDLE.
- Latency:
  - Request seen in IDLE (cycle 0): creq_valid at cycle 1.
  - Accept at cycle k: earliest response at k+1; data_ok one cycle after cresp_valid.
  - Minimum round trip is 4 cycles.
- Boundaries:
  - cresp_valid in IDLE, REQ or DONE is ignored.
  - creq_ready while creq_valid=0 is ignored.
  - A store and a fetch never overlap.
  - Reset in any state aborts the transaction with no data_ok, and a late cresp_valid after reset is ignored.
  - Continuous dreq can starve ireq under fixed priority; this is acceptable because the core stalls fetch behind memory ops.

Optional Feature:
- Macro: CORE_BUS_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit rr pointer flips to the other port after each DONE whose owner matched the pointer. When both ports are valid in IDLE, the port named by the pointer wins.
- Undefined: fixed data-priority arbitration as above, and no pointer register exists.

Test Plan:
- Fetch only: ireq_addr=0x8000_0004, creq_ready=1 in cycle 1, cresp_data=0x1111_2222_3333_4444 in cycle 2.
  - Required: creq_size=2, creq_strobe=0, iresp_data_ok=1 in cycle 3 only, iresp_data=0x1111_2222.
- Simultaneous: ireq_addr=0x8000_0000 and a store to dreq_addr=0x8010_0008 (strobe=0xFF, data=0xDEAD_BEEF), both in cycle 0.
  - Required: the store is issued first with creq_data=0xDEAD_BEEF, dresp_data_ok pulses, then the fetch is issued with creq_addr=0x8000_0000.
- Backpressure: hold creq_ready=0 for 5 cycles.
  - Required: creq_valid stays high and creq_addr/creq_data stay constant for all 5 cycles; exactly one transaction completes.
- Stale: change ireq_addr from 0x8000_0010 to 0x8000_0100 while in WAIT.
  - Required: no iresp_data_ok for the old address; the next grant uses 0x8000_0100.
- Reset mid-WAIT, then cresp_valid=1 in the following cycle.
  - Required: no data_ok, state IDLE, creq_valid=0.
- With CORE_BUS_ARB_RR_EN defined: both ports valid continuously.
  - Required: grants alternate D, I, D, I across 4 transactions.
